// File: rtl/connect_four_buttons.sv
// Push-button conditioner for the connect_four core: synchronize, debounce, edge-detect and arbitrate.
// Define CONNECT_FOUR_BUTTON_REPEAT_EN to add hold-to-repeat on the left/right moves.
module connect_four_buttons #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_right_raw,
  input  logic btn_left_raw,
  input  logic btn_drop_raw,
  output logic move_right,
  output logic move_left,
  output logic drop_piece,
  output logic right_held,
  output logic left_held,
  output logic drop_held
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam int BR = 0;
  localparam int BL = 1;
  localparam int BD = 2;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("connect_four_buttons: illegal parameter value");
  end

  logic [2:0]    raw_norm;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    stable_q, stable_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    press_cand, cand;
  logic          move_right_q, move_left_q, drop_piece_q;
  logic          move_right_d, move_left_d, drop_piece_d;

  assign raw_norm = {btn_drop_raw, btn_left_raw, btn_right_raw} ^ {3{BTN_ACTIVE_LOW}};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    for (int b = 0; b < 3; b++) begin
      stable_d[b] = stable_q[b];
      cnt_d[b]    = '0;
      if (sync2_q[b] != stable_q[b]) begin
        if (cnt_q[b] == CNT_MAX) stable_d[b] = sync2_q[b];
        else                     cnt_d[b]    = cnt_q[b] + CW'(1);
      end
    end
  end

  assign press_cand = stable_d & ~stable_q;

`ifdef CONNECT_FOUR_BUTTON_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  // Index 0 is right, 1 is left; a direction repeats only while pressed alone.
  logic [RW-1:0] rep_cnt_q [2];
  logic [RW-1:0] rep_cnt_d [2];
  logic [1:0]    rep_first_q, rep_first_d, rep_cand;

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      rep_cand[d]    = 1'b0;
      rep_cnt_d[d]   = '0;
      rep_first_d[d] = 1'b1;
      if (stable_q[d] && !stable_q[1-d]) begin
        rep_first_d[d] = rep_first_q[d];
        if (rep_cnt_q[d] == (rep_first_q[d] ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1))) begin
          rep_cand[d]    = 1'b1;
          rep_first_d[d] = 1'b0;
        end else begin
          rep_cnt_d[d] = rep_cnt_q[d] + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q[0] <= '0;
      rep_cnt_q[1] <= '0;
      rep_first_q  <= 2'b11;
    end else begin
      rep_cnt_q[0] <= rep_cnt_d[0];
      rep_cnt_q[1] <= rep_cnt_d[1];
      rep_first_q  <= rep_first_d;
    end
  end

  assign cand = press_cand | {1'b0, rep_cand};
`else
  assign cand = press_cand;
`endif

  // Drop wins outright; simultaneous left+right cancel. Masking with the own
  // registered pulse keeps any output from staying high two cycles in a row.
  always_comb begin
    drop_piece_d = cand[BD] & ~drop_piece_q;
    move_right_d = cand[BR] & ~cand[BD] & ~cand[BL] & ~move_right_q;
    move_left_d  = cand[BL] & ~cand[BD] & ~cand[BR] & ~move_left_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      cnt_q[0]     <= '0;
      cnt_q[1]     <= '0;
      cnt_q[2]     <= '0;
      move_right_q <= 1'b0;
      move_left_q  <= 1'b0;
      drop_piece_q <= 1'b0;
    end else begin
      sync1_q      <= raw_norm;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      cnt_q[0]     <= cnt_d[0];
      cnt_q[1]     <= cnt_d[1];
      cnt_q[2]     <= cnt_d[2];
      move_right_q <= move_right_d;
      move_left_q  <= move_left_d;
      drop_piece_q <= drop_piece_d;
    end
  end

  assign move_right = move_right_q;
  assign move_left  = move_left_q;
  assign drop_piece = drop_piece_q;
  assign right_held = stable_q[BR];
  assign left_held  = stable_q[BL];
  assign drop_held  = stable_q[BD];

endmodule

// File: doc/connect_four_buttons.md
# connect_four_buttons

Input conditioner that turns the three raw player push-buttons into the clean single-cycle command pulses `move_right`, `move_left` and `drop_piece` consumed by the `connect_four` game core. It sits between the board pins and the game instance in the top level and is the producing end of the game's command interface. Per button it provides a two-flop synchronizer, a stability debouncer and a press edge detector. It also arbitrates conflicting commands and, optionally, generates hold-to-repeat for cursor moves.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive cycles a synchronized level must differ from the debounced state before it is accepted (20 ms at 50 MHz). Must be ≥ 2.
- `REPEAT_DELAY`, default 25_000_000: cycles from the initial move pulse to the first repeat pulse.
- `REPEAT_PERIOD`, default 10_000_000: cycles between subsequent repeat pulses.
- `BTN_ACTIVE_LOW`, default 0: 1 inverts all three raw inputs before synchronization.

Ports:
- `clk` in 1: system clock. This block has one clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `btn_right_raw` in 1: asynchronous raw right button.
- `btn_left_raw` in 1: asynchronous raw left button.
- `btn_drop_raw` in 1: asynchronous raw drop button.
- `move_right` out 1: one-cycle command pulse.
- `move_left` out 1: one-cycle command pulse.
- `drop_piece` out 1: one-cycle command pulse.
- `right_held` out 1: debounced level of the right button.
- `left_held` out 1: debounced level of the left button.
- `drop_held` out 1: debounced level of the drop button.

## Operation
- Polarity: each raw input is normalized so that 1 means pressed. When `BTN_ACTIVE_LOW`=1 the raw input is inverted.
- Synchronizer: two flops per button. The output of the second flop is `s`.
- Debouncer, per button: a counter of width `$clog2(DEBOUNCE_CYCLES)`.
  - `s == stable`: counter clears.
  - `s != stable`, counter below `DEBOUNCE_CYCLES-1`: counter increments.
  - `s != stable`, counter at `DEBOUNCE_CYCLES-1`: `stable` takes `s` and the counter clears.
  - Any bounce shorter than `DEBOUNCE_CYCLES` is discarded.
- Candidate pulse: a 0→1 transition of `stable` produces a one-cycle candidate. A 1→0 transition produces nothing.
- Arbitration, evaluated in the same cycle as the candidates:
  - Drop candidate present: `drop_piece` fires and any move candidate that cycle is discarded, not deferred.
  - Left and right candidates together, no drop: both are discarded.
  - Otherwise each candidate passes through to its output.
- `*_held` outputs are the `stable` registers.
- Every output is registered. The pulse outputs are never high for two consecutive cycles.

## Timing
- Reset values: all synchronizer flops, `stable` registers, counters and outputs are 0.
- Reset mid-operation clears all state immediately. A repeat sequence in progress is abandoned.
- Latency: the raw input is pressed before sampling edge 0 and held. The pulse output is high for exactly the single cycle following edge `DEBOUNCE_CYCLES+1`.
  - The second synchronizer flop updates at edge 1.
  - The counter counts at edges 2 through `DEBOUNCE_CYCLES+1`.
  - `stable` and the pulse update at that last edge.
- Release: `*_held` falls `DEBOUNCE_CYCLES+1` edges after the release is first sampled.
- Button held through reset deassertion: it is treated as a new press and one pulse is produced with the latency above.

## Configuration
- Macro: `CONNECT_FOUR_BUTTON_REPEAT_EN`.
- Defined: auto-repeat applies to left and right only. A repeat counter per direction runs while that button's `stable` is 1 and the opposite button's `stable` is 0.
  - First repeat candidate: `REPEAT_DELAY` cycles after the initial pulse cycle.
  - Further repeat candidates: every `REPEAT_PERIOD` cycles after that.
  - Release, or the opposite button becoming pressed, clears the counter.
  - Repeat candidates go through the same arbitration as press candidates.
  - `drop_piece` never repeats.
- Undefined: no repeat logic is present. A press produces exactly one pulse, and `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8, `BTN_ACTIVE_LOW`=0.
- Reset and idle: `rst_n` low with inputs toggling, then held 0 → all outputs 0 throughout. After release, all outputs stay 0.
- Clean press: `btn_right_raw` rises before edge 0 and is held 100 cycles → `move_right` is high only after edge 5, `right_held`=1 from edge 5.
  - Without the macro, no further pulse.
  - With the macro, further pulses at +20, +28, +36 cycles.
- Bounce: `btn_left_raw` high 3 cycles, low 1, high 3, low → no `move_left` pulse and `left_held` stays 0.
- Conflicts: left and right rise together → no move pulses, both `*_held`=1. Drop and right rise together → one `drop_piece` pulse and no `move_right`.
- Async reset mid-hold: assert `rst_n` low while `left_held`=1 → all outputs 0 in the same cycle. Release with the button still pressed → one `move_left` pulse 5 edges later.
- Active-low: `BTN_ACTIVE_LOW`=1, `btn_drop_raw` idle high, then driven low and held → one `drop_piece` pulse after edge 5, and `drop_held`=1.
